// File: rtl/nway_cache_store_if.sv
// Tag/data access bus between the cache controller FSM (master) and nway_cache_store (slave).
// Optional hit-detect signals are present only when HIT_DETECT_EN is defined.
interface nway_cache_store_if #(
  parameter int N_WAYS  = 4,
  parameter int INDEX_W = 10,
  parameter int TAG_W   = 18,
  parameter int LINE_W  = 128
);
  localparam int WAY_W = (N_WAYS > 1) ? $clog2(N_WAYS) : 1;
  localparam int TE_W  = TAG_W + 2;

  logic [WAY_W-1:0]         way;
  logic                     tag_we;
  logic [INDEX_W-1:0]       tag_index;
  logic [TE_W-1:0]          tag_wdata;
  logic [N_WAYS*TE_W-1:0]   tag_rdata;
  logic                     data_we;
  logic [INDEX_W-1:0]       data_index;
  logic [LINE_W-1:0]        data_wdata;
  logic [LINE_W-1:0]        data_rdata;
`ifdef HIT_DETECT_EN
  logic [TAG_W-1:0]         lookup_tag;
  logic                     hit;
  logic [WAY_W-1:0]         hit_way;

  modport master (
    output way, tag_we, tag_index, tag_wdata, data_we, data_index, data_wdata, lookup_tag,
    input  tag_rdata, data_rdata, hit, hit_way
  );
  modport slave (
    input  way, tag_we, tag_index, tag_wdata, data_we, data_index, data_wdata, lookup_tag,
    output tag_rdata, data_rdata, hit, hit_way
  );
`else
  modport master (
    output way, tag_we, tag_index, tag_wdata, data_we, data_index, data_wdata,
    input  tag_rdata, data_rdata
  );
  modport slave (
    input  way, tag_we, tag_index, tag_wdata, data_we, data_index, data_wdata,
    output tag_rdata, data_rdata
  );
`endif
endinterface

// File: rtl/nway_cache_store.sv
// Tag and data storage for the N-way set-associative cache: parallel tag read, one-way data read.
// Optional macro HIT_DETECT_EN adds combinational lookup_tag/hit/hit_way compare logic.
module nway_cache_store #(
  parameter int N_WAYS  = 4,
  parameter int INDEX_W = 10,
  parameter int TAG_W   = 18,
  parameter int LINE_W  = 128
) (
  input  logic              clk,
  input  logic              rst_n,
  nway_cache_store_if.slave bus
);
  localparam int WAY_W  = (N_WAYS > 1) ? $clog2(N_WAYS) : 1;
  localparam int TE_W   = TAG_W + 2;
  localparam int N_SETS = 1 << INDEX_W;

  logic [TE_W-1:0]   tag_mem  [N_SETS][N_WAYS];
  logic [LINE_W-1:0] data_mem [N_SETS][N_WAYS];

  // An entry reads as zero until written after the last reset; this stands in for
  // clearing the whole tag array and also discards any tag write made during reset.
  logic [N_SETS-1:0][N_WAYS-1:0] live;

  logic                        way_ok;
  logic [N_WAYS-1:0][TE_W-1:0] ent;

  if ((1 << WAY_W) == N_WAYS) begin : g_way_full
    assign way_ok = 1'b1;
  end else begin : g_way_part
    assign way_ok = int'(bus.way) < N_WAYS;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      live <= '0;
    end else if (bus.tag_we && way_ok) begin
      live[bus.tag_index][bus.way] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (bus.tag_we && way_ok) begin
      tag_mem[bus.tag_index][bus.way] <= bus.tag_wdata;
    end
  end

  // Data lines keep their contents through reset; the reset branch only blocks writes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
    end else if (bus.data_we && way_ok) begin
      data_mem[bus.data_index][bus.way] <= bus.data_wdata;
    end
  end

  always_comb begin
    ent = '0;
    for (int k = 0; k < N_WAYS; k++) begin
      if (live[bus.tag_index][k]) begin
        ent[k] = tag_mem[bus.tag_index][k];
      end
    end
  end

  assign bus.tag_rdata  = ent;
  assign bus.data_rdata = way_ok ? data_mem[bus.data_index][bus.way] : '0;

`ifdef HIT_DETECT_EN
  logic             hit_c;
  logic [WAY_W-1:0] hit_way_c;

  // Scan from the top way down so the lowest matching way wins.
  always_comb begin
    hit_c     = 1'b0;
    hit_way_c = '0;
    for (int k = N_WAYS - 1; k >= 0; k--) begin
      if (ent[k][TE_W-1] && (ent[k][TAG_W-1:0] == bus.lookup_tag)) begin
        hit_c     = 1'b1;
        hit_way_c = WAY_W'(k);
      end
    end
  end

  assign bus.hit     = hit_c;
  assign bus.hit_way = hit_way_c;
`endif
endmodule

// File: tb/tb_nway_cache_store.sv
// Self-checking bench for nway_cache_store: directed vectors plus an array model checked every cycle.
module tb_nway_cache_store;
  localparam int N_WAYS  = 4;
  localparam int INDEX_W = 10;
  localparam int TAG_W   = 18;
  localparam int LINE_W  = 128;
  localparam int WAY_W   = 2;
  localparam int TE_W    = TAG_W + 2;
  localparam int N_SETS  = 1 << INDEX_W;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  nway_cache_store_if #(.N_WAYS(N_WAYS), .INDEX_W(INDEX_W), .TAG_W(TAG_W), .LINE_W(LINE_W)) bus ();

  nway_cache_store #(.N_WAYS(N_WAYS), .INDEX_W(INDEX_W), .TAG_W(TAG_W), .LINE_W(LINE_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  // Model: plain arrays of what each entry/line must hold.
  logic [TE_W-1:0]   m_tag  [N_SETS][N_WAYS];
  logic [LINE_W-1:0] m_data [N_SETS][N_WAYS];
  bit                m_dw   [N_SETS][N_WAYS];

  task automatic model_clear_tags();
    for (int s = 0; s < N_SETS; s++)
      for (int w = 0; w < N_WAYS; w++)
        m_tag[s][w] = '0;
  endtask

  initial begin
    model_clear_tags();
    for (int s = 0; s < N_SETS; s++)
      for (int w = 0; w < N_WAYS; w++)
        m_dw[s][w] = 1'b0;
  end

  always @(negedge rst_n) model_clear_tags();

  always @(posedge clk) begin
    if (rst_n === 1'b1) begin
      if (bus.tag_we) m_tag[bus.tag_index][bus.way] = bus.tag_wdata;
      if (bus.data_we) begin
        m_data[bus.data_index][bus.way] = bus.data_wdata;
        m_dw[bus.data_index][bus.way]   = 1'b1;
      end
    end
  end

  function automatic logic [N_WAYS*TE_W-1:0] exp_tags(input int idx);
    logic [N_WAYS*TE_W-1:0] r;
    for (int k = 0; k < N_WAYS; k++) r[k*TE_W +: TE_W] = m_tag[idx][k];
    return r;
  endfunction

  task automatic chk(input string nm, input logic [LINE_W-1:0] act, input logic [LINE_W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

`ifdef HIT_DETECT_EN
  function automatic logic [WAY_W:0] exp_hit(input int idx, input logic [TAG_W-1:0] lt);
    for (int k = 0; k < N_WAYS; k++)
      if (m_tag[idx][k][TE_W-1] && m_tag[idx][k][TAG_W-1:0] == lt)
        return {1'b1, WAY_W'(k)};
    return '0;
  endfunction
`endif

  always @(negedge clk) begin
    chk("cmp_tag", LINE_W'(bus.tag_rdata), LINE_W'(exp_tags(int'(bus.tag_index))));
    if (m_dw[bus.data_index][bus.way])
      chk("cmp_data", bus.data_rdata, m_data[bus.data_index][bus.way]);
`ifdef HIT_DETECT_EN
    chk("cmp_hit", LINE_W'({bus.hit, bus.hit_way}),
        LINE_W'(exp_hit(int'(bus.tag_index), bus.lookup_tag)));
`endif
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  localparam logic [LINE_W-1:0] DBEEF = 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D;
  localparam logic [LINE_W-1:0] OLD7  = 128'h0F0F0F0F_11112222_33334444_55556666;
  localparam logic [LINE_W-1:0] NEW7  = 128'hA5A5A5A5_77778888_9999AAAA_BBBBCCCC;

  initial begin
    int idx_list [3] = '{0, 511, 1023};
    bus.way        = '0;
    bus.tag_we     = 1'b0;
    bus.tag_index  = '0;
    bus.tag_wdata  = '0;
    bus.data_we    = 1'b0;
    bus.data_index = '0;
    bus.data_wdata = '0;
`ifdef HIT_DETECT_EN
    bus.lookup_tag = '0;
`endif
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    foreach (idx_list[i]) begin
      bus.tag_index = INDEX_W'(idx_list[i]);
      #1 chk("rst_tag", LINE_W'(bus.tag_rdata), '0);
    end

    bus.tag_index = 10'd5;
    bus.way       = 2'd2;
    bus.tag_wdata = {1'b1, 1'b0, 18'h2ABCD};
    bus.tag_we    = 1'b1;
    step();
    bus.tag_we = 1'b0;
    #1 chk("tag_idx5", LINE_W'(bus.tag_rdata), LINE_W'({20'h0, 20'hAABCD, 20'h0, 20'h0}));

    bus.data_index = 10'd1023;
    bus.way        = 2'd3;
    bus.data_wdata = DBEEF;
    bus.data_we    = 1'b1;
    step();
    bus.data_we = 1'b0;
    #1 chk("data_w3", bus.data_rdata, DBEEF);
    bus.way        = 2'd0;
    bus.data_wdata = 128'h1;
    bus.data_we    = 1'b1;
    step();
    bus.data_we = 1'b0;
    #1 chk("data_w0", bus.data_rdata, 128'h1);
    bus.way = 2'd3;
    #1 chk("data_w3_kept", bus.data_rdata, DBEEF);

    bus.data_index = 10'd7;
    bus.way        = 2'd1;
    bus.data_wdata = OLD7;
    bus.data_we    = 1'b1;
    step();
    bus.tag_index  = 10'd7;
    bus.tag_wdata  = {1'b1, 1'b1, 18'h15555};
    bus.tag_we     = 1'b1;
    bus.data_wdata = NEW7;
    #1 chk("nobypass_data", bus.data_rdata, OLD7);
    chk("nobypass_tag", LINE_W'(bus.tag_rdata), '0);
    step();
    bus.tag_we  = 1'b0;
    bus.data_we = 1'b0;
    #1 chk("both_data", bus.data_rdata, NEW7);
    chk("both_tag", LINE_W'(bus.tag_rdata), LINE_W'({20'h0, 20'h0, 20'hD5555, 20'h0}));

    for (int i = 0; i < 12; i++) begin
      bus.tag_index  = INDEX_W'((i * 37 + 3) % N_SETS);
      bus.data_index = INDEX_W'((i * 91 + 200) % N_SETS);
      bus.way        = WAY_W'(i % N_WAYS);
      bus.tag_wdata  = TE_W'(i * 12345 + 7);
      bus.data_wdata = {4{32'(i * 32'h01010101 + 1)}};
      bus.tag_we     = 1'b1;
      bus.data_we    = (i % 2 == 0);
      step();
    end
    bus.tag_we  = 1'b0;
    bus.data_we = 1'b0;
    for (int i = 0; i < 12; i++) begin
      bus.tag_index  = INDEX_W'((i * 37 + 3) % N_SETS);
      bus.data_index = INDEX_W'((i * 91 + 200) % N_SETS);
      bus.way        = WAY_W'(i % N_WAYS);
      step();
    end

    bus.tag_index = 10'd9;
    bus.way       = 2'd0;
    bus.tag_wdata = 20'hFFFFF;
    bus.tag_we    = 1'b1;
    step();
    #1 chk("tag_idx9", LINE_W'(bus.tag_rdata), LINE_W'({60'h0, 20'hFFFFF}));
    bus.way       = 2'd1;
    bus.tag_wdata = 20'hC1234;
    #1 rst_n = 1'b0;
    #1 chk("async_clr", LINE_W'(bus.tag_rdata), '0);
    step();
    bus.tag_we = 1'b0;
    #1 rst_n = 1'b1;
    step();
    chk("no_commit", LINE_W'(bus.tag_rdata), '0);
    bus.data_index = 10'd1023;
    bus.way        = 2'd3;
    #1 chk("data_kept_rst", bus.data_rdata, DBEEF);

`ifdef HIT_DETECT_EN
    bus.tag_index = 10'd3;
    bus.tag_wdata = {1'b1, 1'b0, 18'h00042};
    bus.tag_we    = 1'b1;
    bus.way       = 2'd1;
    step();
    bus.way = 2'd3;
    step();
    bus.tag_we     = 1'b0;
    bus.lookup_tag = 18'h00042;
    #1 chk("hit_w1", LINE_W'({bus.hit, bus.hit_way}), LINE_W'(3'b101));
    bus.way       = 2'd1;
    bus.tag_wdata = {1'b0, 1'b0, 18'h00042};
    bus.tag_we    = 1'b1;
    step();
    bus.tag_we = 1'b0;
    #1 chk("hit_w3", LINE_W'({bus.hit, bus.hit_way}), LINE_W'(3'b111));
    bus.lookup_tag = 18'h00043;
    #1 chk("hit_none", LINE_W'({bus.hit, bus.hit_way}), '0);
    step();
`endif

    step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
